count_step_monitor: RTL

Downstream checker for the 3-bit up/down counter stage: samples the counter's `count` output every clock, classifies each transition (hold, up step, down step, wrap, illegal jump), and tracks the current count direction with a small state machine. It raises one-cycle event pulses, a sticky fault flag and a run-length of consecutive same-direction steps. Status consumers and the bench scoreboard use these outputs instead of re-deriving them from raw `count`.

---
 rtl/count_step_monitor_if.sv | 18 +
 rtl/count_step_monitor.sv | 96 +++++++++
 2 files changed

// File: rtl/count_step_monitor_if.sv
// count_step_monitor_if: observed count, fault clear and classification outputs of the step monitor.
interface count_step_monitor_if #(parameter int WIDTH = 3, parameter int RUN_W = 8);
   logic [WIDTH-1:0] count;
   logic             clr_err;
   logic [1:0]       dir;
   logic             step_up;
   logic             step_dn;
   logic             wrap_up;
   logic             wrap_dn;
   logic             err;
   logic             err_sticky;
   logic [RUN_W-1:0] run_len;
   logic [7:0]       wrap_cnt;
   modport master (output count, clr_err,
                   input dir, step_up, step_dn, wrap_up, wrap_dn, err, err_sticky, run_len, wrap_cnt);
   modport slave  (input count, clr_err,
                   output dir, step_up, step_dn, wrap_up, wrap_dn, err, err_sticky, run_len, wrap_cnt);
endinterface

// File: rtl/count_step_monitor.sv
// count_step_monitor: classifies counter transitions and tracks direction, run length and faults.
// Define COUNT_MON_STATS_EN to enable the wrap_cnt statistics counter; otherwise wrap_cnt reads 0.
module count_step_monitor #(
   parameter int WIDTH = 3,
   parameter int RUN_W = 8
) (
   input logic                clk,
   input logic                reset,
   count_step_monitor_if.slave mon
);
   typedef enum logic [2:0] {PRIME, IDLE, UP, DOWN, FAULT} state_t;
   localparam logic [RUN_W-1:0] RUN_MAX = '1;
   state_t           state, state_n;
   logic [WIDTH-1:0] prev, delta;
   logic [RUN_W-1:0] run_n;
   logic             is_up, is_dn, is_hold;
   logic             su_n, sd_n, wu_n, wd_n, err_n, sticky_n;
   assign delta   = mon.count - prev;
   assign is_hold = delta == '0;
   assign is_up   = delta == WIDTH'(1);
   assign is_dn   = delta == '1;
   assign mon.dir = state == UP ? 2'b01 : state == DOWN ? 2'b10 : state == FAULT ? 2'b11 : 2'b00;
   always_comb begin
      state_n  = state;
      su_n     = 1'b0;
      sd_n     = 1'b0;
      wu_n     = 1'b0;
      wd_n     = 1'b0;
      err_n    = 1'b0;
      sticky_n = mon.err_sticky;
      run_n    = mon.run_len;
      if (mon.clr_err) begin
         state_n  = PRIME;
         sticky_n = 1'b0;
         run_n    = '0;
      end else begin
         case (state)
            PRIME: begin
               state_n = IDLE;
               run_n   = '0;
            end
            FAULT: run_n = '0;
            default: begin
               // a step opposite to (or out of) the current direction restarts the run at 1
               if (is_up) begin
                  state_n = UP;
                  su_n    = 1'b1;
                  wu_n    = prev == '1;
                  run_n   = state != UP ? RUN_W'(1) : mon.run_len == RUN_MAX ? RUN_MAX : mon.run_len + 1'b1;
               end else if (is_dn) begin
                  state_n = DOWN;
                  sd_n    = 1'b1;
                  wd_n    = prev == '0;
                  run_n   = state != DOWN ? RUN_W'(1) : mon.run_len == RUN_MAX ? RUN_MAX : mon.run_len + 1'b1;
               end else if (!is_hold) begin
                  state_n  = FAULT;
                  err_n    = 1'b1;
                  sticky_n = 1'b1;
                  run_n    = '0;
               end
            end
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= PRIME;
         prev           <= '0;
         mon.step_up    <= 1'b0;
         mon.step_dn    <= 1'b0;
         mon.wrap_up    <= 1'b0;
         mon.wrap_dn    <= 1'b0;
         mon.err        <= 1'b0;
         mon.err_sticky <= 1'b0;
         mon.run_len    <= '0;
      end else begin
         state          <= state_n;
         prev           <= mon.count;
         mon.step_up    <= su_n;
         mon.step_dn    <= sd_n;
         mon.wrap_up    <= wu_n;
         mon.wrap_dn    <= wd_n;
         mon.err        <= err_n;
         mon.err_sticky <= sticky_n;
         mon.run_len    <= run_n;
      end
   end
`ifdef COUNT_MON_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mon.wrap_cnt <= '0;
      else if (wu_n || wd_n) mon.wrap_cnt <= mon.wrap_cnt + 8'd1;
   end
`else
   assign mon.wrap_cnt = '0;
`endif
endmodule
